// File: rtl/ce_pkg.sv
// ---------------------------------------------------------------------------
// ce_pkg
// Shared helpers for the convolution MAC engine.
//   clog2       - ceiling log2 used to size the adder tree (clog2(1) = 0).
//   N, T        - tap count and tree depth for the default 3x3 kernel.
//   ce_latency  - accept-edge to out_valid-edge distance for kernel edge k.
// ---------------------------------------------------------------------------
package ce_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    localparam int CE_KERNEL = 3;
    localparam int N         = CE_KERNEL * CE_KERNEL;
    localparam int T         = clog2(N);

    // Input stage, multiply stage, sign-extension stage, T tree levels and
    // the accumulator give clog2(k*k)+3 edges from accept to out_valid.
    function automatic int ce_latency(input int k);
        return clog2(k * k) + 3;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// ---------------------------------------------------------------------------
// mac_adder_tree
// Registered reduction of N signed operands into one WIDTH-bit sum.
// Stage 0 registers the operands sign-extended to WIDTH; then clog2(N)
// registered pairwise-add levels follow. An unpaired operand at a level is
// passed through into the next level's register.
// A valid bit and a sideband word travel alongside each operand set.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   en_i        - hold enable; when low every register keeps its value
//   valid_i     - operand set present
//   operands_i  - N packed signed operands, operand j at [IN_WIDTH*j +: IN_WIDTH]
//   sb_i        - sideband word aligned with the operands
//   valid_o     - sum_o / sb_o valid
//   sum_o       - signed sum of the operand set
//   sb_o        - sideband that entered with that operand set
//   busy_o      - any operand set in flight
// ---------------------------------------------------------------------------
module mac_adder_tree
    import ce_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int WIDTH    = 32,
    parameter int N        = 9,
    parameter int SB_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [N*IN_WIDTH-1:0] operands_i,
    input  logic [SB_WIDTH-1:0]   sb_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      sum_o,
    output logic [SB_WIDTH-1:0]   sb_o,
    output logic                  busy_o
);

    localparam int T_LVLS = clog2(N);
    localparam int DEPTH  = T_LVLS + 1;
    // One spare slot so the pair index 2*j+1 never leaves the array.
    localparam int SLOTS  = N + 1;

    logic signed [WIDTH-1:0] lvl_q [DEPTH][SLOTS];
    logic signed [WIDTH-1:0] lvl_d [DEPTH][SLOTS];
    logic [DEPTH-1:0]        vld_q;
    logic [SB_WIDTH-1:0]     sb_q [DEPTH];

    always_comb begin
        int prev_cnt;
        for (int l = 0; l < DEPTH; l++) begin
            for (int j = 0; j < SLOTS; j++) begin
                lvl_d[l][j] = '0;
            end
        end
        for (int j = 0; j < N; j++) begin
            lvl_d[0][j] = WIDTH'($signed(operands_i[IN_WIDTH*j +: IN_WIDTH]));
        end
        for (int l = 1; l < DEPTH; l++) begin
            // Number of live operands in the previous level.
            prev_cnt = (N + (1 << (l - 1)) - 1) >> (l - 1);
            for (int j = 0; j < (N + 1) / 2; j++) begin
                if (2 * j + 1 < prev_cnt) begin
                    lvl_d[l][j] = lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1];
                end else if (2 * j < prev_cnt) begin
                    lvl_d[l][j] = lvl_q[l-1][2*j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= '{default: '0};
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                sb_q[s] <= '0;
            end
        end else if (en_i) begin
            lvl_q    <= lvl_d;
            vld_q[0] <= valid_i;
            sb_q[0]  <= sb_i;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                sb_q[s]  <= sb_q[s-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign sum_o   = lvl_q[DEPTH-1][0];
    assign sb_o    = sb_q[DEPTH-1];
    assign busy_o  = |vld_q;

endmodule

// File: rtl/conv_mac_engine.sv
// ---------------------------------------------------------------------------
// conv_mac_engine
// KxK signed multiply-accumulate engine. Each accepted beat carries one data
// window and one weight window; their dot products are accumulated across
// input channels and emitted as one result on the beat flagged in_last.
// Pipeline: input stage -> multiply stage -> mac_adder_tree -> accumulator.
//
// Handshake: a beat transfers on an edge where in_valid && in_ready; a result
// transfers on an edge where out_valid && out_ready. The whole pipeline,
// including the accumulator, freezes while a result waits (out_valid &&
// !out_ready), so in_ready is simply the inverse of that stall.
//
// Build option: define CE_RELU_EN to clamp negative results to zero on the
// output register; the running accumulator always keeps the raw sum.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input beat handshake
//   in_last           - beat is the final input channel of the output
//   in_tag            - tag, taken from the last beat of a group
//   data, weight      - packed signed taps, tap i at [DATA_WIDTH*i +: DATA_WIDTH]
//   out_valid/out_ready - result handshake
//   result            - signed accumulated dot product
//   out_tag           - tag of the last beat that produced result
//   busy              - beat in flight or partial accumulation open
// ---------------------------------------------------------------------------
module conv_mac_engine
    import ce_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL     = 3,
    parameter int ACC_WIDTH  = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [TAG_WIDTH-1:0]                in_tag,
    input  logic [DATA_WIDTH*KERNEL*KERNEL-1:0] data,
    input  logic [DATA_WIDTH*KERNEL*KERNEL-1:0] weight,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_WIDTH-1:0]                result,
    output logic [TAG_WIDTH-1:0]                out_tag,
    output logic                                busy
);

    localparam int N_TAPS = KERNEL * KERNEL;
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int VW     = DATA_WIDTH * N_TAPS;

    logic stall;

    // Input stage
    logic                 s0_vld_q;
    logic                 s0_last_q;
    logic [TAG_WIDTH-1:0] s0_tag_q;
    logic [VW-1:0]        s0_data_q;
    logic [VW-1:0]        s0_weight_q;

    // Multiply stage
    logic [PW*N_TAPS-1:0] prod_d;
    logic [PW*N_TAPS-1:0] s1_prod_q;
    logic                 s1_vld_q;
    logic                 s1_last_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    // Tree outputs
    logic                 tree_vld;
    logic [ACC_WIDTH-1:0] tree_sum;
    logic [TAG_WIDTH:0]   tree_sb;
    logic                 tree_busy;
    logic                 tree_last;
    logic [TAG_WIDTH-1:0] tree_tag;

    // Accumulator stage
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] result_d;
    logic                        first_q;
    logic [ACC_WIDTH-1:0]        result_q;
    logic [TAG_WIDTH-1:0]        out_tag_q;
    logic                        out_valid_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q    <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_tag_q    <= '0;
            s0_data_q   <= '0;
            s0_weight_q <= '0;
        end else if (!stall) begin
            // in_ready is high whenever we get here, so in_valid alone marks an accept.
            s0_vld_q    <= in_valid;
            s0_last_q   <= in_last;
            s0_tag_q    <= in_tag;
            s0_data_q   <= data;
            s0_weight_q <= weight;
        end
    end

    // Operands are widened to the product width first so the low PW bits
    // of the multiply hold the exact signed product.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            prod_d[PW*i +: PW] = PW'($signed(s0_data_q[DATA_WIDTH*i +: DATA_WIDTH]))
                               * PW'($signed(s0_weight_q[DATA_WIDTH*i +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_prod_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_tag_q  <= '0;
        end else if (!stall) begin
            s1_prod_q <= prod_d;
            s1_vld_q  <= s0_vld_q;
            s1_last_q <= s0_last_q;
            s1_tag_q  <= s0_tag_q;
        end
    end

    mac_adder_tree #(
        .IN_WIDTH (PW),
        .WIDTH    (ACC_WIDTH),
        .N        (N_TAPS),
        .SB_WIDTH (TAG_WIDTH + 1)
    ) u_tree (
        .clk        (clk),
        .rst        (rst),
        .en_i       (!stall),
        .valid_i    (s1_vld_q),
        .operands_i (s1_prod_q),
        .sb_i       ({s1_last_q, s1_tag_q}),
        .valid_o    (tree_vld),
        .sum_o      (tree_sum),
        .sb_o       (tree_sb),
        .busy_o     (tree_busy)
    );

    assign tree_last = tree_sb[TAG_WIDTH];
    assign tree_tag  = tree_sb[TAG_WIDTH-1:0];

    // The first beat of a group ignores whatever the accumulator holds.
    assign acc_next = (first_q ? '0 : acc_q) + $signed(tree_sum);

`ifdef CE_RELU_EN
    assign result_d = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
`else
    assign result_d = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            result_q    <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            // Not stalled means any pending result was taken this edge.
            out_valid_q <= 1'b0;
            if (tree_vld) begin
                if (tree_last) begin
                    result_q    <= result_d;
                    out_tag_q   <= tree_tag;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    first_q     <= 1'b1;
                end else begin
                    acc_q   <= acc_next;
                    first_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign busy      = s0_vld_q || s1_vld_q || tree_busy || !first_q;

endmodule
